// File: rtl/alu_arbiter_pkg.sv
// Shared opcodes, FSM states and owner encoding for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_ILLEGAL = 3'b011;
    localparam logic [2:0] OP_NOR     = 3'b100;
    localparam logic [2:0] OP_XOR     = 3'b101;
    localparam logic [2:0] OP_SUB     = 3'b110;
    localparam logic [2:0] OP_MUL     = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_R0 = 1'b0,
        OWN_R1 = 1'b1
    } owner_e;

    // Signed add/sub overflow: effective operand signs agree but the result sign differs.
    function automatic logic sgn_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = is_sub ? ~b_msb : b_msb;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant: the pointer names the requester that wins a tie.
module rr_grant2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req0_i && (!req1_i || !ptr_i)) begin
                gnt_o[0] = 1'b1;
            end else if (req1_i) begin
                gnt_o[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// One shared ALU, two requesters; one operation in flight, result returned on the owner's
// valid/ready response channel.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             r0_valid_i,
    output logic             r0_ready_o,
    input  logic [WIDTH-1:0] r0_a_i,
    input  logic [WIDTH-1:0] r0_b_i,
    input  logic [2:0]       r0_op_i,
    input  logic             r0_unsig_i,
    output logic             r0_rsp_valid_o,
    input  logic             r0_rsp_ready_i,
    output logic [WIDTH-1:0] r0_result_o,
    output logic             r0_overflow_o,
    output logic             r0_illegal_o,

    input  logic             r1_valid_i,
    output logic             r1_ready_o,
    input  logic [WIDTH-1:0] r1_a_i,
    input  logic [WIDTH-1:0] r1_b_i,
    input  logic [2:0]       r1_op_i,
    input  logic             r1_unsig_i,
    output logic             r1_rsp_valid_o,
    input  logic             r1_rsp_ready_i,
    output logic [WIDTH-1:0] r1_result_o,
    output logic             r1_overflow_o,
    output logic             r1_illegal_o
);

    localparam int CW = (MUL_CYCLES < 1) ? 1 : $clog2(MUL_CYCLES + 1);

    state_e                  state_q;
    owner_e                  owner_q;
    owner_e                  ptr_q;
    logic [WIDTH-1:0]        a_q;
    logic [WIDTH-1:0]        b_q;
    logic [2:0]              op_q;
    logic                    unsig_q;
    logic [CW-1:0]           cnt_q;

    logic [1:0]              rsp_valid_q;
    logic [1:0][WIDTH-1:0]   result_q;
    logic [1:0]              ovf_q;
    logic [1:0]              ill_q;

    logic [1:0]              gnt;
    logic [1:0]              rsp_rdy;

    assign rsp_rdy = {r1_rsp_ready_i, r0_rsp_ready_i};

    rr_grant2 u_grant (
        .req0_i (r0_valid_i),
        .req1_i (r1_valid_i),
        .ptr_i  (ptr_q == OWN_R1),
        .en_i   (state_q == IDLE),
        .gnt_o  (gnt)
    );

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign r0_ready_o = rst_ni & gnt[0];
    assign r1_ready_o = rst_ni & gnt[1];

    assign r0_rsp_valid_o = rsp_valid_q[0];
    assign r0_result_o    = result_q[0];
    assign r0_overflow_o  = ovf_q[0];
    assign r0_illegal_o   = ill_q[0];
    assign r1_rsp_valid_o = rsp_valid_q[1];
    assign r1_result_o    = result_q[1];
    assign r1_overflow_o  = ovf_q[1];
    assign r1_illegal_o   = ill_q[1];

    // ALU datapath, fed only from the latched operand registers.
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;

    assign sum    = a_q + b_q;
    assign diff   = a_q - b_q;
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits the signed product.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op_q)
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_XOR: alu_res = a_q ^ b_q;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = !unsig_q && sgn_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = !unsig_q && sgn_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            OP_MUL: begin
                if (unsig_q) begin
                    alu_res = prod_u[WIDTH-1:0];
                    alu_ovf = |prod_u[2*WIDTH-1:WIDTH];
                end else begin
                    alu_res = prod_s[WIDTH-1:0];
                    alu_ovf = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
                end
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= OWN_R0;
            ptr_q       <= OWN_R0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
            unsig_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            result_q    <= '0;
            ovf_q       <= '0;
            ill_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        owner_q <= gnt[1] ? OWN_R1 : OWN_R0;
                        a_q     <= gnt[1] ? r1_a_i     : r0_a_i;
                        b_q     <= gnt[1] ? r1_b_i     : r0_b_i;
                        op_q    <= gnt[1] ? r1_op_i    : r0_op_i;
                        unsig_q <= gnt[1] ? r1_unsig_i : r0_unsig_i;
                        cnt_q   <= CW'(MUL_CYCLES);
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // mul sits here MUL_CYCLES extra cycles; everything else leaves on the first.
                    if (op_q == OP_MUL && cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q[owner_q]    <= alu_res;
                        ovf_q[owner_q]       <= alu_ovf;
                        ill_q[owner_q]       <= alu_ill;
                        rsp_valid_q[owner_q] <= 1'b1;
                        state_q              <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_rdy[owner_q]) begin
                        rsp_valid_q[owner_q] <= 1'b0;
                        ptr_q                <= (owner_q == OWN_R0) ? OWN_R1 : OWN_R0;
                        state_q              <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int MC = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_ready, r0_unsig, r0_rsp_valid, r0_rsp_ready, r0_overflow, r0_illegal;
    logic [W-1:0]  r0_a, r0_b, r0_result;
    logic [2:0]    r0_op;
    logic          r1_valid, r1_ready, r1_unsig, r1_rsp_valid, r1_rsp_ready, r1_overflow, r1_illegal;
    logic [W-1:0]  r1_a, r1_b, r1_result;
    logic [2:0]    r1_op;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ptr_m  = 0;

    alu_arbiter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_a_i(r0_a), .r0_b_i(r0_b),
        .r0_op_i(r0_op), .r0_unsig_i(r0_unsig), .r0_rsp_valid_o(r0_rsp_valid),
        .r0_rsp_ready_i(r0_rsp_ready), .r0_result_o(r0_result), .r0_overflow_o(r0_overflow),
        .r0_illegal_o(r0_illegal),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_a_i(r1_a), .r1_b_i(r1_b),
        .r1_op_i(r1_op), .r1_unsig_i(r1_unsig), .r1_rsp_valid_o(r1_rsp_valid),
        .r1_rsp_ready_i(r1_rsp_ready), .r1_result_o(r1_result), .r1_overflow_o(r1_overflow),
        .r1_illegal_o(r1_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int r);
        return (r != 0) ? r1_ready : r0_ready;
    endfunction
    function automatic logic rv(input int r);
        return (r != 0) ? r1_rsp_valid : r0_rsp_valid;
    endfunction
    function automatic logic [31:0] res(input int r);
        return (r != 0) ? r1_result : r0_result;
    endfunction
    function automatic logic [1:0] flags(input int r);
        return (r != 0) ? {r1_overflow, r1_illegal} : {r0_overflow, r0_illegal};
    endfunction

    task automatic drv(input int r, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic u);
        if (r != 0) begin r1_valid = v; r1_a = a; r1_b = b; r1_op = op; r1_unsig = u; end
        else        begin r0_valid = v; r0_a = a; r0_b = b; r0_op = op; r0_unsig = u; end
    endtask

    task automatic set_rr(input int r, input logic v);
        if (r != 0) r1_rsp_ready = v; else r0_rsp_ready = v;
    endtask

    // Reference model: plain 64-bit arithmetic on the operation's mathematical meaning.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic u, output logic [31:0] r, output logic o,
                                  output logic il);
        longint sa, sb, s;
        logic [63:0] up;
        longint smax, smin;
        smax = 64'sh7FFFFFFF;
        smin = -64'sh80000000;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0; o = 0; il = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd4: r = ~(a | b);
            3'd5: r = a ^ b;
            3'd2: begin s = sa + sb; r = s[31:0]; o = !u && (s > smax || s < smin); end
            3'd6: begin s = sa - sb; r = s[31:0]; o = !u && (s > smax || s < smin); end
            3'd7: begin
                if (u) begin
                    up = {32'd0, a} * {32'd0, b};
                    r = up[31:0];
                    o = up[63:32] != 0;
                end else begin
                    s = sa * sb;
                    r = s[31:0];
                    o = (s > smax || s < smin);
                end
            end
            default: il = 1;
        endcase
    endfunction

    // One complete transaction on requester r; hold<0 raises rsp_ready before the response.
    task automatic run_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic u, input int hold,
                          input logic [31:0] er, input logic eo, input logic ei);
        int n, acc, elat;
        elat = (op == 3'b111) ? 2 + MC : 2;
        @(negedge clk);
        if (hold < 0) set_rr(r, 1'b1);
        drv(r, 1'b1, a, b, op, u);
        #1;
        n = 0;
        while (!rdy(r) && n < 50) begin @(negedge clk); #1; n++; end
        chk({tag, " grant"}, 32'(rdy(r)), 32'd1);
        acc = cyc;
        @(negedge clk);
        drv(r, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        n = 0;
        while (!rv(r) && n < 50) begin @(negedge clk); n++; end
        chk({tag, " latency"}, 32'(cyc - acc), 32'(elat));
        chk({tag, " result"}, res(r), er);
        chk({tag, " ovf/ill"}, 32'(flags(r)), 32'({eo, ei}));
        chk({tag, " other rsp_valid"}, 32'(rv(1 - r)), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " held"}, {res(r)[30:0], rv(r)}, {er[30:0], 1'b1});
        end
        set_rr(r, 1'b1);
        @(negedge clk);
        chk({tag, " rsp cleared"}, 32'(rv(r)), 32'd0);
        set_rr(r, 1'b0);
        ptr_m = 1 - r;
    endtask

    // Both requesters valid together: winner is the model's pointer, loser follows right after.
    task automatic tie_round(input string tag);
        int w, l, n;
        logic [31:0] er [2];
        er[0] = 32'h0000000F;
        er[1] = 32'h000000FF;
        w = ptr_m; l = 1 - w;
        @(negedge clk);
        drv(0, 1'b1, 32'h000000FF, 32'h0000000F, 3'b000, 1'b0);
        drv(1, 1'b1, 32'h000000F0, 32'h0000000F, 3'b001, 1'b0);
        #1;
        chk({tag, " tie ready"}, {30'd0, r1_ready, r0_ready}, (w != 0) ? 32'd2 : 32'd1);
        @(negedge clk);
        drv(w, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        n = 0;
        while (!rv(w) && n < 50) begin @(negedge clk); n++; end
        chk({tag, " winner result"}, res(w), er[w]);
        chk({tag, " loser waits"}, 32'(rdy(l)), 32'd0);
        set_rr(w, 1'b1);
        @(negedge clk);
        #1;
        chk({tag, " loser granted"}, 32'(rdy(l)), 32'd1);
        set_rr(w, 1'b0);
        @(negedge clk);
        drv(l, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        n = 0;
        while (!rv(l) && n < 50) begin @(negedge clk); n++; end
        chk({tag, " loser result"}, res(l), er[l]);
        set_rr(l, 1'b1);
        @(negedge clk);
        set_rr(l, 1'b0);
        ptr_m = w;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        int          r;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        u;
        int          hold;
        logic [31:0] er;
        logic        eo, ei;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        logic [31:0] a, b, er;
        logic [2:0]  op;
        logic        u, eo, ei;
        int          r, hold;

        tbl.push_back('{0, 32'd5,        32'd7,        3'b010, 1'b0,  0, 32'd12,       1'b0, 1'b0});
        tbl.push_back('{1, 32'h7FFFFFFF, 32'd1,        3'b010, 1'b0,  1, 32'h80000000, 1'b1, 1'b0});
        tbl.push_back('{1, 32'h7FFFFFFF, 32'd1,        3'b010, 1'b1, -1, 32'h80000000, 1'b0, 1'b0});
        tbl.push_back('{0, 32'h00010000, 32'h00010000, 3'b111, 1'b0,  0, 32'h00000000, 1'b1, 1'b0});
        tbl.push_back('{0, 32'hFFFFFFFE, 32'd3,        3'b111, 1'b0, -1, 32'hFFFFFFFA, 1'b0, 1'b0});
        tbl.push_back('{1, 32'd123,      32'd456,      3'b011, 1'b0,  0, 32'h00000000, 1'b0, 1'b1});
        tbl.push_back('{0, 32'h80000000, 32'd1,        3'b110, 1'b0,  0, 32'h7FFFFFFF, 1'b1, 1'b0});
        tbl.push_back('{0, 32'h80000000, 32'd1,        3'b110, 1'b1,  2, 32'h7FFFFFFF, 1'b0, 1'b0});
        tbl.push_back('{1, 32'hF0F0F0F0, 32'h0F0F0000, 3'b100, 1'b0,  0, 32'h00000F0F, 1'b0, 1'b0});
        tbl.push_back('{1, 32'hFFFF0000, 32'h0F0F0F0F, 3'b101, 1'b0, -1, 32'hF0F00F0F, 1'b0, 1'b0});
        tbl.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b1,  0, 32'h00000001, 1'b1, 1'b0});
        tbl.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0,  0, 32'h00000001, 1'b0, 1'b0});
        tbl.push_back('{1, 32'd5,        32'd7,        3'b110, 1'b1,  0, 32'hFFFFFFFE, 1'b0, 1'b0});
        tbl.push_back('{1, 32'h80000000, 32'h80000000, 3'b010, 1'b0,  0, 32'h00000000, 1'b1, 1'b0});

        rst_n = 1'b0;
        drv(0, 1'b1, 32'd1, 32'd2, 3'b010, 1'b0);
        drv(1, 1'b1, 32'd3, 32'd4, 3'b010, 1'b0);
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ready", {30'd0, r1_ready, r0_ready}, 32'd0);
        chk("reset rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
        chk("reset flags", {28'd0, r1_overflow, r1_illegal, r0_overflow, r0_illegal}, 32'd0);
        chk("reset r0_result", r0_result, 32'd0);
        chk("reset r1_result", r1_result, 32'd0);
        drv(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        drv(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        repeat (2) @(negedge clk);

        tie_round("tie1");
        tie_round("tie2");

        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].u,
                   tbl[i].hold, tbl[i].er, tbl[i].eo, tbl[i].ei);

        // Pointer now follows whoever was served last.
        run_op("pre_tie", 0, 32'd1, 32'd1, 3'b010, 1'b0, 0, 32'd2, 1'b0, 1'b0);
        tie_round("tie3");

        // Backpressure: r0 result held 4 cycles while r1 waits for the handshake.
        @(negedge clk);
        drv(0, 1'b1, 32'h10, 32'h20, 3'b010, 1'b0);
        #1;
        n = 0;
        while (!r0_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("bp grant", 32'(r0_ready), 32'd1);
        @(negedge clk);
        drv(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        drv(1, 1'b1, 32'd3, 32'd5, 3'b000, 1'b0);
        n = 0;
        while (!r0_rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            chk("bp held", {r0_result[29:0], r0_rsp_valid, r1_ready}, {30'h30, 1'b1, 1'b0});
            @(negedge clk);
        end
        r0_rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp r1 granted", {30'd0, r0_rsp_valid, r1_ready}, 32'd1);
        r0_rsp_ready = 1'b0;
        @(negedge clk);
        drv(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        n = 0;
        while (!r1_rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp r1 result", r1_result, 32'd1);
        r1_rsp_ready = 1'b1;
        @(negedge clk);
        r1_rsp_ready = 1'b0;

        // Reset in the middle of a multiply: abandoned, no late response.
        @(negedge clk);
        drv(0, 1'b1, 32'd5, 32'd6, 3'b111, 1'b0);
        #1;
        n = 0;
        while (!r0_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("mulrst grant", 32'(r0_ready), 32'd1);
        @(negedge clk);
        drv(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mulrst flags", {26'd0, r1_ready, r0_ready, r1_rsp_valid, r0_rsp_valid,
                             r1_overflow | r1_illegal, r0_overflow | r0_illegal}, 32'd0);
        chk("mulrst r0_result", r0_result, 32'd0);
        chk("mulrst r1_result", r1_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mulrst no stale rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
        end
        tie_round("tie_after_rst");

        for (int k = 0; k < 40; k++) begin
            r    = int'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            u    = 1'($urandom_range(0, 1));
            a    = pick();
            b    = pick();
            hold = int'($urandom_range(0, 3)) - 1;
            model(op, a, b, u, er, eo, ei);
            run_op($sformatf("rnd%0d", k), r, a, b, op, u, hold, er, eo, ei);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
